// File: rtl/skinny_sbox8_dom1_dep_lanes.sv
// skinny_sbox8_dom1_dep_lanes
// NLANES parallel first-order DOM-dep masked SKINNY-128 8-bit S-boxes behind
// a valid/ready handshake. Operands and randomness are captured once per
// operation. A small sequencer waits for the four gadget layers to settle,
// then registers the output shares.
module skinny_sbox8_dom1_dep_lanes #(
    parameter int NLANES  = 1,
    parameter bit ZEROISE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NLANES-1:0]   si0,
    input  logic [8*NLANES-1:0]   si1,
    input  logic [16*NLANES-1:0]  r,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NLANES-1:0]   bo0,
    output logic [8*NLANES-1:0]   bo1,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_cnt;
    logic                   w_accept;

    logic [8*NLANES-1:0]    r_si0_q;
    logic [8*NLANES-1:0]    r_si1_q;
    logic [16*NLANES-1:0]   r_r_q;

    logic [8*NLANES-1:0]    w_bo0_next;
    logic [8*NLANES-1:0]    w_bo1_next;

    assign w_accept = (r_state == IDLE) && in_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: EVAL lasts four edges so the deepest layer has settled
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)      w_state_next = EVAL;
            EVAL:    if (r_cnt == 2'd3) w_state_next = CAPT;
            CAPT:                       w_state_next = DONE;
            DONE:    if (out_ready)     w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the state register
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        busy      = (r_state != IDLE);
    end

    // Evaluation cycle counter, restarted on every accepted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= 2'd0;
        end else if (r_state == EVAL) begin
            r_cnt <= r_cnt + 2'd1;
        end
    end

    // Operand/randomness capture; optionally wiped once the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_si0_q <= '0;
            r_si1_q <= '0;
            r_r_q   <= '0;
        end else if (w_accept) begin
            r_si0_q <= si0;
            r_si1_q <= si1;
            r_r_q   <= r;
        end else if (ZEROISE && (r_state == CAPT)) begin
            r_si0_q <= '0;
            r_si1_q <= '0;
            r_r_q   <= '0;
        end
    end

    // Output share registers, loaded only in the single CAPT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bo0 <= '0;
            bo1 <= '0;
        end else if (r_state == CAPT) begin
            bo0 <= w_bo0_next;
            bo1 <= w_bo1_next;
        end
    end

    // Per-lane gadget network. Bit g of each vector belongs to gadget q<g>.
    // Gadget: x = NOT a (share 0 inverted), y = NOT b likewise.
    // Registered: x0, x1, yb = y0^r0^y1, m_s = (x_s & r0)^r1^z_s.
    // Share s output: (x_s & yb) ^ m_s, so the XOR of shares is (x & y) ^ z.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NLANES; gi++) begin : gen_lane
            logic [7:0] w_b0, w_b1;
            logic [7:0] w_a0, w_a1, w_c0, w_c1, w_z0, w_z1;
            logic [7:0] w_rr0, w_rr1;
            logic [7:0] w_q0, w_q1;
            logic [7:0] r_x0, r_x1, r_yb, r_m0, r_m1;

            assign w_b0 = r_si0_q[8*gi +: 8];
            assign w_b1 = r_si1_q[8*gi +: 8];

            // Two randomness bits per gadget, q0 taking the lowest pair
            for (gj = 0; gj < 8; gj++) begin : gen_rnd
                assign w_rr0[gj] = r_r_q[16*gi + 2*gj];
                assign w_rr1[gj] = r_r_q[16*gi + 2*gj + 1];
            end

            // Gadget operands, listed q7 down to q0
            assign w_a0 = {w_q0[4], w_q0[3], w_q0[2], w_q0[1], w_q0[0], w_b0[2], w_b0[3], w_b0[7]};
            assign w_a1 = {w_q1[4], w_q1[3], w_q1[2], w_q1[1], w_q1[0], w_b1[2], w_b1[3], w_b1[7]};
            assign w_c0 = {w_q0[5], w_q0[0], w_q0[3], w_b0[3], w_q0[1], w_b0[1], w_b0[2], w_b0[6]};
            assign w_c1 = {w_q1[5], w_q1[0], w_q1[3], w_b1[3], w_q1[1], w_b1[1], w_b1[2], w_b1[6]};
            assign w_z0 = {w_b0[2], w_b0[3], w_b0[7], w_b0[1], w_b0[5], w_b0[6], w_b0[0], w_b0[4]};
            assign w_z1 = {w_b1[2], w_b1[3], w_b1[7], w_b1[1], w_b1[5], w_b1[6], w_b1[0], w_b1[4]};

            // Single register stage of every gadget in this lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_x0 <= '0;
                    r_x1 <= '0;
                    r_yb <= '0;
                    r_m0 <= '0;
                    r_m1 <= '0;
                end else begin
                    r_x0 <= ~w_a0;
                    r_x1 <= w_a1;
                    r_yb <= (~w_c0 ^ w_rr0) ^ w_c1;
                    r_m0 <= (~w_a0 & w_rr0) ^ w_rr1 ^ w_z0;
                    r_m1 <= (w_a1 & w_rr0) ^ w_rr1 ^ w_z1;
                end
            end

            assign w_q0 = (r_x0 & r_yb) ^ r_m0;
            assign w_q1 = (r_x1 & r_yb) ^ r_m1;

            assign w_bo0_next[8*gi +: 8] = {w_q0[3], w_q0[0], w_q0[1], w_q0[6],
                                            w_q0[4], w_q0[2], w_q0[5], w_q0[7]};
            assign w_bo1_next[8*gi +: 8] = {w_q1[3], w_q1[0], w_q1[1], w_q1[6],
                                            w_q1[4], w_q1[2], w_q1[5], w_q1[7]};
        end
    endgenerate

endmodule
